// File: rtl/fixed_parallel_accumulator_pkg.sv
// Shared types and helpers for the parallel accumulator.
// FIXED_PARALLEL_ACCUMULATOR_SATURATE_EN selects saturating (defined) or wrapping narrowing.
package fixed_parallel_accumulator_pkg;

  typedef logic [0:0] state_t;
  localparam state_t IDLE  = 1'b0;
  localparam state_t ACCUM = 1'b1;

  localparam int WIDE = 64;

  // A zero-length window behaves as a single beat; oversize requests are clamped.
  function automatic int clamp_depth(input int d, input int max_d);
    if (d <= 0) return 1;
    if (d > max_d) return max_d;
    return d;
  endfunction

  function automatic logic signed [WIDE-1:0] narrow(input logic signed [WIDE-1:0] v,
                                                    input int out_w);
    logic signed [WIDE-1:0] hi;
    logic signed [WIDE-1:0] lo;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
`ifdef FIXED_PARALLEL_ACCUMULATOR_SATURATE_EN
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
`else
    if (lo > hi) return v;
    return (v <<< (WIDE - out_w)) >>> (WIDE - out_w);
`endif
  endfunction

endpackage

// File: rtl/fixed_acc_lane.sv
// One accumulator lane: sign extension, running sum and narrowed window result.
module fixed_acc_lane
  import fixed_parallel_accumulator_pkg::*;
#(
  parameter int IN_WIDTH  = 16,
  parameter int ACC_WIDTH = 22,
  parameter int OUT_WIDTH = 22
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 first,
  input  logic [IN_WIDTH-1:0]  data_in,
  output logic [OUT_WIDTH-1:0] result
);

  logic signed [IN_WIDTH-1:0]  in_s;
  logic signed [ACC_WIDTH-1:0] ext;
  logic signed [ACC_WIDTH-1:0] sum;
  logic signed [ACC_WIDTH-1:0] acc_p1;
  logic signed [WIDE-1:0]      sum_wide;

  assign in_s     = data_in;
  assign ext      = ACC_WIDTH'(in_s);
  // The first beat of a window ignores whatever the register holds.
  assign sum      = first ? ext : acc_p1 + ext;
  assign sum_wide = WIDE'(sum);
  assign result   = OUT_WIDTH'(narrow(sum_wide, OUT_WIDTH));

  // Stage p1: running accumulator
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_p1 <= '0;
    end else if (en) begin
      acc_p1 <= sum;
    end
  end

endmodule

// File: rtl/fixed_parallel_accumulator.sv
// Multi-lane runtime-depth accumulator with a one-entry output holding register.
// Optional FIXED_PARALLEL_ACCUMULATOR_SATURATE_EN makes output narrowing saturate.
module fixed_parallel_accumulator
  import fixed_parallel_accumulator_pkg::*;
#(
  parameter int PARALLELISM = 4,
  parameter int IN_WIDTH    = 16,
  parameter int MAX_DEPTH   = 64,
  parameter int DEPTH_WIDTH = $clog2(MAX_DEPTH + 1),
  parameter int ACC_WIDTH   = IN_WIDTH + $clog2(MAX_DEPTH),
  parameter int OUT_WIDTH   = ACC_WIDTH
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [DEPTH_WIDTH-1:0]           depth,
  input  logic [PARALLELISM*IN_WIDTH-1:0]  data_in,
  input  logic                             data_in_valid,
  output logic                             data_in_ready,
  output logic [PARALLELISM*OUT_WIDTH-1:0] data_out,
  output logic                             data_out_valid,
  input  logic                             data_out_ready
);

  state_t                          state;
  logic [DEPTH_WIDTH-1:0]          cnt;
  logic [DEPTH_WIDTH-1:0]          depth_q;
  logic [DEPTH_WIDTH-1:0]          depth_eff;
  logic [DEPTH_WIDTH:0]            cnt_next;
  logic                            first;
  logic                            last;
  logic                            accept;
  logic [PARALLELISM*OUT_WIDTH-1:0] lane_res;

  assign first     = (state == IDLE);
  assign depth_eff = first ? DEPTH_WIDTH'(clamp_depth(int'(depth), MAX_DEPTH)) : depth_q;
  assign cnt_next  = (DEPTH_WIDTH+1)'(cnt) + (DEPTH_WIDTH+1)'(1);
  assign last      = (cnt_next >= (DEPTH_WIDTH+1)'(depth_eff));
  // Only a completing beat can collide with an unread result.
  assign data_in_ready = !(last && data_out_valid && !data_out_ready);
  assign accept    = data_in_valid && data_in_ready;

  for (genvar i = 0; i < PARALLELISM; i++) begin : g_lane
    fixed_acc_lane #(
      .IN_WIDTH (IN_WIDTH),
      .ACC_WIDTH(ACC_WIDTH),
      .OUT_WIDTH(OUT_WIDTH)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .en     (accept),
      .first  (first),
      .data_in(data_in[i*IN_WIDTH +: IN_WIDTH]),
      .result (lane_res[i*OUT_WIDTH +: OUT_WIDTH])
    );
  end

  // Window control
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      depth_q <= '0;
    end else if (accept) begin
      if (first) depth_q <= depth_eff;
      if (last) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        state <= ACCUM;
        cnt   <= cnt_next[DEPTH_WIDTH-1:0];
      end
    end
  end

  // Output holding register: a new result wins over a same-cycle drain
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out       <= '0;
      data_out_valid <= 1'b0;
    end else if (accept && last) begin
      data_out       <= lane_res;
      data_out_valid <= 1'b1;
    end else if (data_out_valid && data_out_ready) begin
      data_out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fixed_parallel_accumulator.sv
// Directed bench: a full-width instance (OUT=ACC=14) and a narrowed one (OUT=8) share stimulus.
module tb_fixed_parallel_accumulator;

  localparam int P  = 4;
  localparam int IW = 8;
  localparam int MD = 64;
  localparam int DW = 7;
  localparam int AW = 14;
  localparam int NW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] depth;
  logic [P*IW-1:0] data_in;
  logic          data_in_valid;
  logic          data_in_ready, n_in_ready;
  logic [P*AW-1:0] data_out;
  logic [P*NW-1:0] n_out;
  logic          data_out_valid, n_out_valid;
  logic          data_out_ready;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fixed_parallel_accumulator #(
    .PARALLELISM(P), .IN_WIDTH(IW), .MAX_DEPTH(MD), .DEPTH_WIDTH(DW),
    .ACC_WIDTH(AW), .OUT_WIDTH(AW)
  ) dut (
    .clk(clk), .rst(rst), .depth(depth), .data_in(data_in),
    .data_in_valid(data_in_valid), .data_in_ready(data_in_ready),
    .data_out(data_out), .data_out_valid(data_out_valid),
    .data_out_ready(data_out_ready)
  );

  fixed_parallel_accumulator #(
    .PARALLELISM(P), .IN_WIDTH(IW), .MAX_DEPTH(MD), .DEPTH_WIDTH(DW),
    .ACC_WIDTH(AW), .OUT_WIDTH(NW)
  ) dut_n (
    .clk(clk), .rst(rst), .depth(depth), .data_in(data_in),
    .data_in_valid(data_in_valid), .data_in_ready(n_in_ready),
    .data_out(n_out), .data_out_valid(n_out_valid),
    .data_out_ready(data_out_ready)
  );

  function automatic logic [P*IW-1:0] pk_in(input int a, input int b, input int c, input int d);
    return {8'(d), 8'(c), 8'(b), 8'(a)};
  endfunction

  function automatic logic [P*AW-1:0] pk_acc(input int a, input int b, input int c, input int d);
    return {14'(d), 14'(c), 14'(b), 14'(a)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input int a, input int b, input int c, input int d);
    data_in       = pk_in(a, b, c, d);
    data_in_valid = 1'b1;
    step();
  endtask

  initial begin
    rst = 1'b1; depth = 7'd4; data_in = '0; data_in_valid = 1'b0; data_out_ready = 1'b1;
    step(); step();
    rst = 1'b0;
    chk("rst_valid", 64'(data_out_valid), 64'd0);
    chk("rst_data", 64'(data_out), 64'd0);
    chk("rst_ready", 64'(data_in_ready), 64'd1);

    // Basic window, depth 4
    depth = 7'd4;
    for (int k = 0; k < 3; k++) beat(1, 2, 3, 4);
    chk("basic_early", 64'(data_out_valid), 64'd0);
    beat(1, 2, 3, 4);
    data_in_valid = 1'b0;
    chk("basic_valid", 64'(data_out_valid), 64'd1);
    chk("basic_sum", 64'(data_out), 64'(pk_acc(4, 8, 12, 16)));
    chk("basic_sum_n", 64'(n_out), 64'(pk_in(4, 8, 12, 16)));
    step();
    chk("basic_drain", 64'(data_out_valid), 64'd0);

    // Runtime depth: 3 (with mid-window change), 0 -> 1, then 5
    depth = 7'd3;
    beat(1, 1, 1, 1);
    depth = 7'd7;
    beat(1, 1, 1, 1);
    beat(1, 1, 1, 1);
    chk("d3_valid", 64'(data_out_valid), 64'd1);
    chk("d3_sum", 64'(data_out), 64'(pk_acc(3, 3, 3, 3)));
    depth = 7'd0;
    beat(5, -5, 7, -7);
    chk("d0_valid", 64'(data_out_valid), 64'd1);
    chk("d0_sum", 64'(data_out), 64'(pk_acc(5, -5, 7, -7)));
    depth = 7'd5;
    for (int k = 0; k < 4; k++) beat(2, -1, 0, 3);
    chk("d5_early", 64'(data_out_valid), 64'd0);
    beat(2, -1, 0, 3);
    data_in_valid = 1'b0;
    chk("d5_sum", 64'(data_out), 64'(pk_acc(10, -5, 0, 15)));
    step();

    // Backpressure, depth 2
    data_out_ready = 1'b0;
    depth = 7'd2;
    beat(1, 1, 1, 1);
    beat(1, 1, 1, 1);
    chk("bp_w1_valid", 64'(data_out_valid), 64'd1);
    data_in = pk_in(3, 3, 3, 3);
    chk("bp_first_ready", 64'(data_in_ready), 64'd1);
    step();
    chk("bp_last_stall", 64'(data_in_ready), 64'd0);
    for (int k = 0; k < 6; k++) step();
    chk("bp_hold", 64'(data_out), 64'(pk_acc(2, 2, 2, 2)));
    chk("bp_still_stall", 64'(data_in_ready), 64'd0);
    data_out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 64'(data_in_ready), 64'd1);
    step();
    data_in_valid = 1'b0;
    chk("bp_swap_valid", 64'(data_out_valid), 64'd1);
    chk("bp_swap_sum", 64'(data_out), 64'(pk_acc(6, 6, 6, 6)));
    step();
    chk("bp_empty", 64'(data_out_valid), 64'd0);

    // Signed extremes, depth MAX_DEPTH
    depth = 7'd64;
    for (int k = 0; k < 63; k++) beat(-128, -128, -128, -128);
    chk("ext_early", 64'(data_out_valid), 64'd0);
    beat(-128, -128, -128, -128);
    data_in_valid = 1'b0;
    chk("ext_sum", 64'(data_out), 64'(pk_acc(-8192, -8192, -8192, -8192)));
`ifdef FIXED_PARALLEL_ACCUMULATOR_SATURATE_EN
    chk("ext_sum_n", 64'(n_out), 64'(pk_in(-128, -128, -128, -128)));
`else
    chk("ext_sum_n", 64'(n_out), 64'(pk_in(0, 0, 0, 0)));
`endif
    step();

    // Depth above MAX_DEPTH clamps to 64
    depth = 7'd100;
    for (int k = 0; k < 63; k++) beat(1, 1, 1, 1);
    chk("clamp_early", 64'(data_out_valid), 64'd0);
    beat(1, 1, 1, 1);
    data_in_valid = 1'b0;
    chk("clamp_sum", 64'(data_out), 64'(pk_acc(64, 64, 64, 64)));
    step();

    // Saturation vs wrap on the narrowed instance
    depth = 7'd4;
    for (int k = 0; k < 4; k++) beat(100, 100, -100, 1);
    data_in_valid = 1'b0;
    chk("sat_full", 64'(data_out), 64'(pk_acc(400, 400, -400, 4)));
`ifdef FIXED_PARALLEL_ACCUMULATOR_SATURATE_EN
    chk("sat_narrow", 64'(n_out), 64'(pk_in(127, 127, -128, 4)));
`else
    chk("wrap_narrow", 64'(n_out), 64'(pk_in(-112, -112, 112, 4)));
`endif
    step();

    // Reset mid-window
    depth = 7'd4;
    beat(1, 1, 1, 1);
    beat(1, 1, 1, 1);
    data_in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_valid", 64'(data_out_valid), 64'd0);
    chk("mid_rst_data", 64'(data_out), 64'd0);
    for (int k = 0; k < 4; k++) beat(1, 1, 1, 1);
    data_in_valid = 1'b0;
    chk("post_rst_valid", 64'(data_out_valid), 64'd1);
    chk("post_rst_sum", 64'(data_out), 64'(pk_acc(4, 4, 4, 4)));
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fixed_parallel_accumulator.md
# fixed_parallel_accumulator

Multi-lane, runtime-depth fixed-point accumulator: sums `depth` consecutive beats of a PARALLELISM-wide vector, lane by lane, and emits one vector of sums per window. Used after the parallel dot-product and matmul datapaths to reduce partial products along the inner dimension. Compared with the single-lane fixed-depth accumulator, it adds:

- parallel lanes;
- runtime depth;
- an output holding register, so the next window accumulates while the previous result waits;
- optional saturating narrowing.

## Interface

Parameters:
- PARALLELISM, 4, number of independent lanes
- IN_WIDTH, 16, signed two's-complement input width per lane
- MAX_DEPTH, 64, largest supported window length
- DEPTH_WIDTH, $clog2(MAX_DEPTH+1), width of `depth` port
- ACC_WIDTH, IN_WIDTH+$clog2(MAX_DEPTH), internal full-precision accumulator width
- OUT_WIDTH, ACC_WIDTH, output width per lane (≤ ACC_WIDTH)

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  reset: synchronous, active-high.
- depth  in  DEPTH_WIDTH  window length. Sampled on the first accepted beat of each window.
- data_in  in  PARALLELISM×IN_WIDTH  input vector; lane i at [i].
- data_in_valid  in  1  input valid.
- data_in_ready  out  1  input ready.
- data_out  out  PARALLELISM×OUT_WIDTH  per-lane window sums.
- data_out_valid  out  1  output valid.
- data_out_ready  in  1  output ready.

## Operation

- State machine with two states:
  - IDLE: no window open.
  - ACCUM: window open; `cnt` beats accepted so far.
- Transitions:
  - IDLE → ACCUM on an accepted beat whose latched depth is > 1.
  - IDLE → IDLE on an accepted beat whose latched depth is ≤ 1; that beat completes a one-beat window.
  - ACCUM → IDLE on the accepted beat where cnt+1 == latched depth (the last beat).
- `depth` handling:
  - Latched on the IDLE-state accept.
  - A value of 0 is treated as 1.
  - Values above MAX_DEPTH are clamped to MAX_DEPTH.
  - Changes to `depth` mid-window are ignored.
- Per lane, each accepted beat is sign-extended to ACC_WIDTH and added:
  - First beat: acc ← sext(in).
  - Later beats: acc ← acc + sext(in).
  - No overflow is possible at ACC_WIDTH.
- On the last beat, the final sum (acc + sext(in)) is narrowed to OUT_WIDTH, written into the output register, and `data_out_valid` is set. The accumulator then restarts cleanly for the next window, with no bubble.
- Output register: one entry. It is freed when data_out_valid && data_out_ready.
- data_in_ready = !(last_beat_pending && data_out_valid && !data_out_ready):
  - Input stalls only when a last beat would overwrite an unconsumed result.
  - The path from data_out_ready to data_in_ready is combinational.
- Simultaneous drain and last-beat load in the same cycle: the new result loads and data_out_valid stays 1.
- Non-last beats are accepted regardless of output state.

## Timing

- Reset values:
  - state = IDLE, cnt = 0, all acc = 0.
  - data_out = 0, data_out_valid = 0.
  - data_in_ready = 1.
- Reset mid-window discards the partial sum and any pending output. It takes effect on the next edge.
- Latency: data_out_valid rises one cycle after the last beat's accept edge.
- Throughput: one beat per cycle sustained when the downstream is always ready. Window k+1's first beat may be accepted in the cycle right after window k's last beat.
- data_out is stable while data_out_valid && !data_out_ready.

## Configuration

- FIXED_PARALLEL_ACCUMULATOR_SATURATE_EN
  - Defined: narrowing ACC_WIDTH → OUT_WIDTH saturates per lane to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
  - Undefined: narrowing keeps the low OUT_WIDTH bits (wraps).
  - When OUT_WIDTH == ACC_WIDTH the two behaviours are identical.

## Structure

- Shared package `fixed_parallel_accumulator_pkg` holds:
  - the state typedef (IDLE, ACCUM);
  - the depth clamp function;
  - the narrowing/saturation function.
- Sub-module `fixed_acc_lane`, one instance per lane. Each instance owns:
  - sign extension;
  - the accumulator register and the clear-on-first-beat mux;
  - narrowing of its result.
- The top owns the FSM, the counter, the depth latch, the output register and the handshake.

## Test plan

- **Basic window.** PARALLELISM=4, depth=4; lane i receives values i+1, i+1, i+1, i+1 with valid held high and ready high. Expect one output, data_out = {16,12,8,4}, one cycle after the 4th accept.
- **Runtime depth change.** depth=3, then depth=0, then depth=5. Expect three windows of lengths 3, 1 and 5. Changing `depth` mid-window has no effect.
- **Backpressure.** data_out_ready=0 for 10 cycles, depth=2, continuous input. Expect:
  - window 2's first beat is accepted;
  - data_in_ready drops on window 2's last beat;
  - window 1's result is held stable;
  - releasing ready drains window 1 and loads window 2 in the same cycle.
- **Signed extremes.** IN_WIDTH=8, depth=MAX_DEPTH=64, all inputs -128. Expect sum -8192 exactly in ACC_WIDTH=14.
- **Saturation vs wrap.** OUT_WIDTH=8, depth=4, inputs 100 each (sum 400):
  - macro defined → 127;
  - macro undefined → 400 mod 256 = 144, read as -112.
- **Reset mid-window.** Assert rst after 2 of 4 beats. Expect:
  - data_out_valid=0 and data_out=0 after reset;
  - the next 4 beats of 1 give an output of 4, not 6.
